// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter (LSB first) fed by a small circular write FIFO.
// The line idles high; consecutive queued bytes go out back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy,
  output logic             tx,
  output logic [1:0]       dbg_state_o
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [BAUD_W-1:0] baud_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q;
  logic              busy_q;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              ovf_q, ovf_d;

  logic              bit_done;
  logic              fifo_nonempty;
  logic              pop;
  logic              push;
  logic [7:0]        head;

  assign bit_done      = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem_q[rd_ptr_q];

  // Write side has no ready: wr_en is a one-cycle push request, and full is the
  // only back-pressure. A push while full is accepted only if the FSM pops on
  // the same edge; otherwise the byte is dropped and overflow pulses.
  assign pop  = fifo_nonempty && ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_done));
  assign push = wr_en && (!full_q || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d   = (count_d == CNT_W'(FIFO_DEPTH));
    ovf_d    = wr_en && full_q && !pop;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // The baud counter restarts on every state change so each bit lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          baud_q <= '0;
          tx_q   <= 1'b1;
          if (fifo_nonempty) begin
            shift_q <= head;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= shift_q[0];
            state_q   <= S_DATA;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= shift_q >> 1;
              tx_q      <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            baud_q <= '0;
            if (fifo_nonempty) begin
              shift_q <= head;
              tx_q    <= 1'b0;
              state_q <= S_START;
            end else begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          baud_q  <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign full        = full_q;
  assign overflow    = ovf_q;
  assign fifo_count  = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a frame-timing queue model checked every cycle, a serial
// receiver that decodes the line mid-bit, and a default-parameter instance for real baud timing.
module tb_uart_tx_fifo;

  localparam int CPB_A = 8;
  localparam int DEPTH = 4;
  localparam int CPB_B = 5208;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en_a = 1'b0, wr_en_b = 1'b0;
  logic [7:0] wr_data_a = '0, wr_data_b = '0;
  logic       full_a, overflow_a, busy_a, tx_a;
  logic       full_b, overflow_b, busy_b, tx_b;
  logic [2:0] count_a, count_b;
  logic [1:0] dbg_a, dbg_b;

  always #10 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB_A), .FIFO_DEPTH(DEPTH), .CNT_W(3)) dut_a (
    .clk(clk), .reset(rst), .wr_en(wr_en_a), .wr_data(wr_data_a),
    .full(full_a), .overflow(overflow_a), .fifo_count(count_a),
    .busy(busy_a), .tx(tx_a), .dbg_state_o(dbg_a)
  );

  uart_tx_fifo dut_b (
    .clk(clk), .reset(rst), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .full(full_b), .overflow(overflow_b), .fifo_count(count_b),
    .busy(busy_b), .tx(tx_b), .dbg_state_o(dbg_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  int tb_cyc = 0;
  int rst_cnt = 0;
  always @(posedge clk) tb_cyc++;
  always @(posedge rst) rst_cnt++;

  // Reference model for instance A: queued bytes plus the time the line becomes free.
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_cur = '0;
  int  m_cyc = 0, m_free_at = 0, m_start = 0, m_pre = 0;
  bit  m_pop = 0, m_ovf = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      if (m_cyc < m_free_at && exp_q.size() > 0) void'(exp_q.pop_back());
      m_q.delete();
      m_free_at = m_cyc;
      m_ovf = 0;
    end else begin
      m_cyc++;
      m_pre = m_q.size();
      m_pop = (m_pre != 0) && (m_cyc >= m_free_at);
      m_ovf = 0;
      if (m_pop) begin
        m_cur = m_q.pop_front();
        exp_q.push_back(m_cur);
        m_start = m_cyc;
        m_free_at = m_cyc + 10 * CPB_A;
      end
      if (wr_en_a) begin
        if (m_pre < DEPTH || m_pop) m_q.push_back(wr_data_a);
        else m_ovf = 1;
      end
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (m_cyc >= m_free_at) return 1'b1;
    idx = (m_cyc - m_start) / CPB_A;
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return m_cur[idx-1];
  endfunction

  bit chk_en = 0;
  int peak = 0;
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("tx", tx_a, exp_tx());
      check("busy", busy_a, m_cyc < m_free_at);
      check("count", count_a, m_q.size());
      check("full", full_a, m_q.size() == DEPTH);
      check("overflow", overflow_a, m_ovf);
      check("state_active", dbg_a != 2'd0, m_cyc < m_free_at);
      if (int'(count_a) > peak) peak = int'(count_a);
    end
  end

  // Serial receiver: detects the start bit, samples each bit at its centre.
  logic [7:0] rx_a[$], rx_b[$];
  logic       stop_a[$], stop_b[$];
  int         start_a[$];

  function automatic logic line(input int which);
    return (which != 0) ? tx_b : tx_a;
  endfunction

  task automatic rx_loop(input int which, input int cpb);
    logic [7:0] b;
    logic sb;
    int r0, t0;
    forever begin
      @(negedge clk);
      if (!rst && line(which) == 1'b0) begin
        r0 = rst_cnt;
        t0 = tb_cyc;
        repeat (cpb / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (cpb) @(negedge clk);
          b[i] = line(which);
        end
        repeat (cpb) @(negedge clk);
        sb = line(which);
        if (rst_cnt == r0) begin
          if (which != 0) begin
            rx_b.push_back(b);
            stop_b.push_back(sb);
          end else begin
            rx_a.push_back(b);
            stop_a.push_back(sb);
            start_a.push_back(t0);
          end
        end
      end
    end
  endtask

  initial rx_loop(0, CPB_A);
  initial rx_loop(1, CPB_B);

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic [7:0] d);
    wr_en_a = en;
    wr_data_a = d;
    @(posedge clk);
    #1;
    wr_en_a = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] d);
    wr_en_b = 1'b1;
    wr_data_b = d;
    @(posedge clk);
    #1;
    wr_en_b = 1'b0;
  endtask

  task automatic score_a(input string tag);
    check({tag, "_rx_count"}, rx_a.size(), exp_q.size());
    while (rx_a.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_rx_byte"}, rx_a.pop_front(), exp_q.pop_front());
      if (stop_a.size() > 0) check({tag, "_stop_bit"}, stop_a.pop_front(), 1);
    end
    rx_a.delete();
    stop_a.delete();
    start_a.delete();
    exp_q.delete();
  endtask

  int n;
  logic [7:0] d;

  initial begin
    #1 rst = 1'b1;
    idle(3);
    rst = 1'b0;
    chk_en = 1;

    // Reset state and idle line
    idle(20);
    check("t1_tx", tx_a, 1);
    check("t1_busy", busy_a, 0);
    check("t1_count", count_a, 0);
    check("t1_full", full_a, 0);
    check("t1_tx_b", tx_b, 1);
    check("t1_busy_b", busy_b, 0);
    check("t1_count_b", count_b, 0);
    check("t1_full_b", full_b, 0);
    check("t1_ovf_b", overflow_b, 0);
    check("t1_state_b", dbg_b, 0);

    // Single byte 0x55: start one cycle after the write, busy for 80 cycles
    drive_a(1'b1, 8'h55);
    check("t2_tx_at_write", tx_a, 1);
    check("t2_count_at_write", count_a, 1);
    idle(1);
    check("t2_tx_fell", tx_a, 0);
    idle(79);
    check("t2_busy_before_end", busy_a, 1);
    idle(1);
    check("t2_busy_dropped", busy_a, 0);
    idle(10);
    check("t2_rx_value", (rx_a.size() > 0) ? rx_a[0] : 8'h00, 8'h55);
    score_a("t2");

    // Three consecutive writes go out back-to-back
    peak = 0;
    drive_a(1'b1, 8'hA3);
    drive_a(1'b1, 8'h0F);
    drive_a(1'b1, 8'hFF);
    idle(260);
    check("t3_count_peak", peak, 2);
    check("t3_frames", start_a.size(), 3);
    if (start_a.size() == 3) begin
      check("t3_gap1", start_a[1] - start_a[0], 10 * CPB_A);
      check("t3_gap2", start_a[2] - start_a[1], 10 * CPB_A);
    end
    score_a("t3");

    // Six consecutive writes into a 4-deep FIFO: one frame in flight, 4 queued, 1 lost
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, 8'($urandom));
      if (i == 3) check("t4_full_after_4", full_a, 0);
      if (i == 4) begin
        check("t4_full_after_5", full_a, 1);
        check("t4_ovf_after_5", overflow_a, 0);
      end
      if (i == 5) check("t4_ovf_after_6", overflow_a, 1);
    end
    idle(1);
    check("t4_ovf_pulse_end", overflow_a, 0);
    idle(5 * 10 * CPB_A + 20);
    check("t4_frames_sent", rx_a.size(), 5);
    score_a("t4");

    // Random writes with random gaps, including overflows
    for (int i = 0; i < 400; i++) begin
      drive_a($urandom_range(0, 3) == 0, 8'($urandom));
    end
    idle(6 * 10 * CPB_A + 20);
    score_a("rand");

    // Reset in the middle of a frame with two bytes queued
    drive_a(1'b1, 8'h3C);
    drive_a(1'b1, 8'($urandom));
    drive_a(1'b1, 8'($urandom));
    idle(20);
    check("t5_count_before", count_a, 2);
    check("t5_busy_before", busy_a, 1);
    #2 rst = 1'b1;
    #1;
    check("t5_tx_on_reset", tx_a, 1);
    check("t5_busy_on_reset", busy_a, 0);
    check("t5_count_on_reset", count_a, 0);
    check("t5_full_on_reset", full_a, 0);
    idle(3);
    rst = 1'b0;
    idle(300);
    check("t5_no_frames", rx_a.size(), 0);
    check("t5_tx_idle", tx_a, 1);
    score_a("t5");

    // Default timing: 10 x 5208-cycle bits, receiver recovers 0x41
    drive_b(8'h41);
    check("t6_tx_at_write", tx_b, 1);
    idle(1);
    check("t6_tx_fell", tx_b, 0);
    n = 0;
    while (busy_b && n < 60000) begin
      idle(1);
      n++;
    end
    check("t6_frame_cycles", n, 10 * CPB_B);
    idle(5);
    check("t6_rx_count", rx_b.size(), 1);
    d = (rx_b.size() > 0) ? rx_b.pop_front() : 8'h00;
    check("t6_rx_byte", d, 8'h41);
    check("t6_stop_bit", (stop_b.size() > 0) ? stop_b.pop_front() : 1'b0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
